// File: rtl/serializador_fila.sv
`timescale 1us/1ns
// -----------------------------------------------------------------------------
// serializador_fila
//
// Read side of the `fila` byte queue. While enabled and the queue reports a
// non-zero occupancy, pops one byte, then shifts it out MSB-first on a one-bit
// valid/ready serial port. After each byte a short gap lets the queue's
// occupancy settle before the next pop decision. At most one pop is ever
// outstanding.
//
// Ports
//   clk_10KHz     in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   enable_in     in   allow new pops (sampled only while idle)
//   data_in       in   queue data_out
//   len_in        in   queue occupancy (len_out)
//   dequeue_out   out  one-cycle pop pulse to queue dequeue_in
//   ready_in      in   downstream accepts the current bit this cycle
//   serial_out    out  current bit, MSB first (0 when not valid)
//   serial_valid  out  serial_out holds a valid bit
//   byte_done     out  one-cycle pulse after the last bit is accepted
//   busy          out  not idle
//   sent_count    out  bytes fully transmitted, wraps 255 -> 0
// -----------------------------------------------------------------------------
module serializador_fila #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                  clk_10KHz,
  input  logic                  reset,
  input  logic                  enable_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [7:0]            len_in,
  output logic                  dequeue_out,
  input  logic                  ready_in,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  byte_done,
  output logic                  busy,
  output logic [7:0]            sent_count
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEQ,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  state_e                state_q,      state_d;
  logic [DATA_WIDTH-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q,    gap_cnt_d;
  logic                  byte_done_q,  byte_done_d;
  logic [7:0]            sent_count_q, sent_count_d;

  // NOTE: every register, including the shift register, is cleared by reset so
  // a byte interrupted mid-flight leaves no residue on serial_out afterwards.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      byte_done_q  <= 1'b0;
      sent_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      byte_done_q  <= byte_done_d;
      sent_count_q <= sent_count_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default for every next-state signal; a branch that forgets
    // one would otherwise infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    byte_done_d  = 1'b0;
    sent_count_d = sent_count_q;

    unique case (state_q)
      IDLE: begin
        // Only place enable_in and len_in are looked at.
        if (enable_in && (len_in != 8'd0)) begin
          state_d = DEQ;
        end
      end
      DEQ: begin
        // The queue presents the popped byte on the edge that ends DEQ.
        state_d = LOAD;
      end
      LOAD: begin
        shift_d   = data_in;
        bit_cnt_d = LAST_BIT;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (ready_in) begin
          shift_d = shift_q << 1;
          if (bit_cnt_q == '0) begin
            state_d      = GAP;
            gap_cnt_d    = GAP_LAST;
            sent_count_d = sent_count_q + 8'd1;
            byte_done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are state decodes or registers only; ready_in never reaches them
  // combinationally.
  assign dequeue_out  = (state_q == DEQ);
  assign serial_valid = (state_q == SHIFT);
  assign serial_out   = serial_valid & shift_q[DATA_WIDTH-1];
  assign busy         = (state_q != IDLE);
  assign byte_done    = byte_done_q;
  assign sent_count   = sent_count_q;

endmodule

// File: tb/tb_serializador_fila.sv
`timescale 1us/1ns
// -----------------------------------------------------------------------------
// tb_serializador_fila
//
// Bench for serializador_fila with a behavioural model of the `fila` queue:
// a pop pulse moves the head byte onto data_in and lowers len_in. All DUT
// outputs are sampled 1 us after the rising edge.
// -----------------------------------------------------------------------------
module tb_serializador_fila;

  logic       clk_10KHz = 1'b0;
  logic       reset     = 1'b0;
  logic       enable_in = 1'b1;
  logic [7:0] data_in   = 8'h00;
  logic [7:0] len_in    = 8'h00;
  logic       ready_in  = 1'b1;
  logic       dequeue_out, serial_out, serial_valid, byte_done, busy;
  logic [7:0] sent_count;

  serializador_fila #(.DATA_WIDTH(8), .GAP_CYCLES(1)) dut (
    .clk_10KHz    (clk_10KHz),
    .reset        (reset),
    .enable_in    (enable_in),
    .data_in      (data_in),
    .len_in       (len_in),
    .dequeue_out  (dequeue_out),
    .ready_in     (ready_in),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .byte_done    (byte_done),
    .busy         (busy),
    .sent_count   (sent_count)
  );

  // 10 kHz: 100 us period.
  always #50 clk_10KHz = ~clk_10KHz;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fifo[$];
  int          cycle = 0;
  int          deq_cnt = 0, bd_cnt = 0;
  int          bd_last = 0, bd_prev = 0;
  int          viol = 0, underflow = 0;
  logic        prev_deq = 1'b0, prev_bd = 1'b0;
  logic [31:0] stream_val = '0;
  int          stream_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    len_in = 8'(fifo.size());
  endtask

  task automatic clear_stats();
    deq_cnt = 0; bd_cnt = 0; stream_val = '0; stream_len = 0;
  endtask

  // One clock: capture the bit accepted at this edge, advance, then sample
  // and run the queue model.
  task automatic tick();
    if (serial_valid && ready_in) begin
      stream_val = {stream_val[30:0], serial_out};
      stream_len++;
    end
    @(posedge clk_10KHz);
    #1;
    cycle++;
    if (!serial_valid && serial_out) viol++;
    if (dequeue_out) begin
      if (prev_deq) viol++;
      deq_cnt++;
      if (fifo.size() > 0) data_in = fifo.pop_front();
      else underflow++;
    end
    prev_deq = dequeue_out;
    if (byte_done) begin
      if (prev_bd) viol++;
      bd_cnt++;
      bd_prev = bd_last;
      bd_last = cycle;
    end
    prev_bd = byte_done;
    len_in = 8'(fifo.size());
  endtask

  task automatic run_until_bd(input int target, input int budget, input string name);
    int n = 0;
    while (bd_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (bd_cnt < target) check({name, "_timeout"}, 32'(bd_cnt), 32'(target));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         stall_at;    // bits accepted before ready drops (0 = no stall)
    int         stall_len;
    logic [7:0] exp_bits;    // expected serial stream, first bit in [7]
    int         exp_cycles;  // cycles from pop decision to byte_done
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #(60000 * 100);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rst_viol;

    // ---------------- reset and empty queue ----------------
    repeat (3) @(posedge clk_10KHz);
    #1;
    check("rst_busy",         32'(busy),         32'd0);
    check("rst_serial_valid", 32'(serial_valid), 32'd0);
    check("rst_sent_count",   32'(sent_count),   32'd0);
    reset = 1'b1;
    rst_viol = 0;
    repeat (50) begin
      tick();
      if (busy || dequeue_out || serial_valid || serial_out || byte_done || sent_count != 8'd0)
        rst_viol++;
    end
    check("empty_deq_pulses", 32'(deq_cnt),  32'd0);
    check("empty_outputs",    32'(rst_viol), 32'd0);

    // ---------------- two bytes back to back ----------------
    clear_stats();
    push(8'h11);
    push(8'h22);
    run_until_bd(2, 100, "two");
    check("two_deq_pulses", 32'(deq_cnt),          32'd2);
    check("two_stream",     stream_val,            32'h0000_1122);
    check("two_stream_len", 32'(stream_len),       32'd16);
    check("two_bd_spacing", 32'(bd_last - bd_prev), 32'd12);
    check("two_sent_count", 32'(sent_count),       32'd2);
    wait_idle();

    // ---------------- table of single bytes ----------------
    vecs[0] = '{8'hA5, 3, 5, 8'b1010_0101, 16, 8'd3};
    vecs[1] = '{8'h11, 0, 0, 8'b0001_0001, 11, 8'd4};
    vecs[2] = '{8'hF0, 0, 0, 8'b1111_0000, 11, 8'd5};
    vecs[3] = '{8'h80, 7, 2, 8'b1000_0000, 13, 8'd6};
    vecs[4] = '{8'h01, 1, 3, 8'b0000_0001, 14, 8'd7};
    vecs[5] = '{8'hFF, 0, 0, 8'b1111_1111, 11, 8'd8};
    vecs[6] = '{8'h3C, 4, 1, 8'b0011_1100, 12, 8'd9};
    for (int i = 0; i < 7; i++) begin
      int n, hold_bad;
      bit stalled;
      clear_stats();
      ready_in = 1'b1;
      push(vecs[i].data);
      n = 0; hold_bad = 0; stalled = 1'b0;
      while (bd_cnt == 0 && n < 100) begin
        tick();
        n++;
        if (!stalled && vecs[i].stall_at > 0 && stream_len == vecs[i].stall_at) begin
          ready_in = 1'b0;
          repeat (vecs[i].stall_len) begin
            tick();
            n++;
            if (!serial_valid || serial_out !== vecs[i].exp_bits[7 - vecs[i].stall_at]) hold_bad++;
          end
          ready_in = 1'b1;
          stalled = 1'b1;
        end
      end
      check($sformatf("vec%0d_stream", i), stream_val, {24'h0, vecs[i].exp_bits});
      check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].exp_cycles));
      check($sformatf("vec%0d_count", i),  32'(sent_count), 32'(vecs[i].exp_count));
      if (vecs[i].stall_at > 0) check($sformatf("vec%0d_hold", i), 32'(hold_bad), 32'd0);
      wait_idle();
    end

    // ---------------- enable gating ----------------
    begin
      int n = 0;
      clear_stats();
      push(8'h31); push(8'h32); push(8'h33);
      while (!serial_valid && n < 10) begin tick(); n++; end
      check("gate_reach_shift", 32'(serial_valid), 32'd1);
      enable_in = 1'b0;
      repeat (40) tick();
      check("gate_bd",     32'(bd_cnt),   32'd1);
      check("gate_deq",    32'(deq_cnt),  32'd1);
      check("gate_len",    32'(len_in),   32'd2);
      check("gate_busy",   32'(busy),     32'd0);
      check("gate_stream", stream_val,    32'h0000_0031);
      enable_in = 1'b1;
      run_until_bd(3, 100, "gate_drain");
      check("gate_deq_total", 32'(deq_cnt), 32'd3);
      check("gate_stream_all", stream_val, 32'h0031_3233);
      wait_idle();
    end

    // ---------------- reset mid-byte ----------------
    begin
      int n = 0;
      clear_stats();
      push(8'hF0); push(8'h5A);
      while (stream_len < 4 && n < 20) begin tick(); n++; end
      check("mid_bits_before_reset", 32'(stream_len), 32'd4);
      #10 reset = 1'b0;
      #1;
      check("mid_rst_busy",   32'(busy),         32'd0);
      check("mid_rst_valid",  32'(serial_valid), 32'd0);
      check("mid_rst_sout",   32'(serial_out),   32'd0);
      check("mid_rst_deq",    32'(dequeue_out),  32'd0);
      check("mid_rst_bd",     32'(byte_done),    32'd0);
      check("mid_rst_count",  32'(sent_count),   32'd0);
      @(negedge clk_10KHz);
      reset = 1'b1;
      stream_val = '0; stream_len = 0; bd_cnt = 0;
      run_until_bd(1, 40, "mid_next");
      check("mid_next_stream", stream_val,       32'h0000_005A);
      check("mid_next_len",    32'(stream_len),  32'd8);
      check("mid_next_count",  32'(sent_count),  32'd1);
      check("mid_deq_total",   32'(deq_cnt),     32'd2);
      wait_idle();
    end

    // ---------------- counter wrap ----------------
    begin
      int n = 0, pushed = 0;
      @(negedge clk_10KHz);
      reset = 1'b0;
      @(negedge clk_10KHz);
      reset = 1'b1;
      clear_stats();
      while (bd_cnt < 257 && n < 4000) begin
        if (fifo.size() < 2 && pushed < 257) begin
          push(8'(pushed));
          pushed++;
        end
        tick();
        n++;
      end
      check("wrap_bd",    32'(bd_cnt),     32'd257);
      check("wrap_deq",   32'(deq_cnt),    32'd257);
      check("wrap_count", 32'(sent_count), 32'd1);
    end

    check("invariants", 32'(viol),      32'd0);
    check("underflow",  32'(underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
